// File: rtl/mem_req_pkg.sv
// Shared types and constants for the data-memory request controller.
// Optional feature macro: MEM_RMW_EN (adds the read-modify-write states).
package mem_req_pkg;

   localparam int unsigned TIMEOUT_DEF = 16;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCESS = 3'd1,
`ifdef MEM_RMW_EN
      ST_RMW_RD = 3'd3,
      ST_RMW_WR = 3'd4,
`endif
      ST_RESP   = 3'd2
   } state_e;

   // Size code 2'b11 is treated as a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      if (size == SZ_BYTE) begin
         return 1'b0;
      end else if (size == SZ_HALF) begin
         return off[0];
      end
      return off != 2'b00;
   endfunction

endpackage

// File: rtl/mem_rmw_merge.sv
// Byte/half lane extract (loads) and lane merge (stores) on a 32-bit word.
// Only present when MEM_RMW_EN is defined.
//   word_i   : word read from memory
//   data_i   : store data; low byte or half is the lane payload
//   off_i    : byte offset within the word
//   size_i   : access size code
//   ext_o    : addressed lane, zero-extended
//   merged_o : word_i with the addressed lane replaced by data_i
`ifdef MEM_RMW_EN
module mem_rmw_merge
   import mem_req_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [31:0] data_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   output logic [31:0] ext_o,
   output logic [31:0] merged_o
);

   always_comb begin
      ext_o    = word_i;
      merged_o = data_i;
      if (size_i == SZ_BYTE) begin
         ext_o    = {24'h0, word_i[{off_i, 3'b000} +: 8]};
         merged_o = word_i;
         merged_o[{off_i, 3'b000} +: 8] = data_i[7:0];
      end else if (size_i == SZ_HALF) begin
         ext_o    = {16'h0, word_i[{off_i[1], 4'b0000} +: 16]};
         merged_o = word_i;
         merged_o[{off_i[1], 4'b0000} +: 16] = data_i[15:0];
      end
   end

endmodule
`endif

// File: rtl/mem_req_ctrl.sv
// Initiator-side controller for a stalling, ready-handshaked 32-bit data memory.
// Takes one load/store at a time, holds the memory request until mem_ready,
// and returns data plus error/timeout status over a valid/ready response.
// Optional feature macro: MEM_RMW_EN (sub-word accesses, store via read-modify-write).
// Ports:
//   clk, rst                     clock, async active-low reset
//   req_valid/req_ready          request handshake; req_wr/addr/wdata/size payload
//   rsp_valid/rsp_ready          response handshake; rsp_rdata/err/timeout payload
//   mem_enable/wr/addr/wdata     memory request, held until mem_ready
//   mem_rdata/mem_ready/mem_err  memory completion
module mem_req_ctrl
   import mem_req_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   input  logic        mem_err
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [15:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              tmo_q, tmo_d;
   logic              timed_out_c;
   logic              mem_wr_c;
   logic [1:0]        acc_size_c;
   logic [31:0]       load_data_c;
   logic [15:0]       mem_addr_c;

`ifdef MEM_RMW_EN
   logic [1:0]        size_q, size_d;
   logic [31:0]       merged_c;

   assign acc_size_c = req_size;
   assign mem_addr_c = {addr_q[15:2], 2'b00};

   mem_rmw_merge u_merge (
      .word_i   (mem_rdata),
      .data_i   (wdata_q),
      .off_i    (addr_q[1:0]),
      .size_i   (size_q),
      .ext_o    (load_data_c),
      .merged_o (merged_c)
   );
`else
   logic unused_size;

   assign unused_size = ^req_size;
   assign acc_size_c  = SZ_WORD;
   assign mem_addr_c  = addr_q;
   assign load_data_c = mem_rdata;
`endif

   // Last allowed wait cycle of a memory phase.
   assign timed_out_c = (cnt_q == CNT_W'(TIMEOUT - 1));

   // State register and captured request / response payload.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
`ifdef MEM_RMW_EN
         size_q  <= SZ_WORD;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
`ifdef MEM_RMW_EN
         size_q  <= size_d;
`endif
      end
   end

   // Next-state and payload update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
`ifdef MEM_RMW_EN
      size_d  = size_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               wr_d    = req_wr;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rdata_d = '0;
               err_d   = 1'b0;
               tmo_d   = 1'b0;
               cnt_d   = '0;
`ifdef MEM_RMW_EN
               size_d  = req_size;
`endif
               if (is_misaligned(acc_size_c, req_addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_ACCESS;
`ifdef MEM_RMW_EN
                  if (req_wr && !req_size[1]) begin
                     state_d = ST_RMW_RD;
                  end
`endif
               end
            end
         end
         ST_ACCESS: begin
            if (mem_ready) begin
               err_d   = mem_err;
               rdata_d = (!wr_q && !mem_err) ? load_data_c : 32'h0;
               state_d = ST_RESP;
            end else if (timed_out_c) begin
               err_d   = 1'b1;
               tmo_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef MEM_RMW_EN
         ST_RMW_RD: begin
            // A failed read aborts the store before anything is written.
            if (mem_ready) begin
               if (mem_err) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  wdata_d = merged_c;
                  cnt_d   = '0;
                  state_d = ST_RMW_WR;
               end
            end else if (timed_out_c) begin
               err_d   = 1'b1;
               tmo_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RMW_WR: begin
            if (mem_ready) begin
               err_d   = mem_err;
               state_d = ST_RESP;
            end else if (timed_out_c) begin
               err_d   = 1'b1;
               tmo_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         ST_RESP: begin
            // Payload clears on handshake so it reads 0 while idle.
            if (rsp_ready) begin
               rdata_d = '0;
               err_d   = 1'b0;
               tmo_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef MEM_RMW_EN
   assign mem_wr_c = (state_q == ST_RMW_WR) || ((state_q == ST_ACCESS) && wr_q);
`else
   assign mem_wr_c = (state_q == ST_ACCESS) && wr_q;
`endif

   // Memory and handshake outputs are decodes of the state register.
   assign mem_enable  = (state_q != ST_IDLE) && (state_q != ST_RESP);
   assign mem_wr      = mem_wr_c;
   assign mem_addr    = mem_enable ? mem_addr_c : 16'h0;
   assign mem_wdata   = mem_wr_c ? wdata_q : 32'h0;
   assign req_ready   = (state_q == ST_IDLE);
   assign rsp_valid   = (state_q == ST_RESP);
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a transaction-level expectation model.
module tb_mem_req_ctrl;
   import mem_req_pkg::*;

   localparam int unsigned TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wr;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        mem_enable, mem_wr, mem_ready, mem_err;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   int n_checks = 0;
   int n_errs   = 0;

   logic        e_rr, e_en, e_wr, e_rv, e_err, e_tmo;
   logic [15:0] e_addr;
   logic [31:0] e_wdata, e_rdata;
   bit          chk_en = 1'b0;
   int          en_cycles = 0;
   int          rsp_count = 0;
   logic [31:0] last_rdata;
   logic        last_err, last_tmo;

   mem_req_ctrl #(.TIMEOUT(TMO), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_exp(input logic rr, input logic en, input logic wr, input logic [15:0] a,
                          input logic [31:0] wd, input logic rv, input logic [31:0] rd,
                          input logic er, input logic tm);
      e_rr = rr; e_en = en; e_wr = wr; e_addr = a; e_wdata = wd;
      e_rv = rv; e_rdata = rd; e_err = er; e_tmo = tm;
   endtask

   task automatic set_idle();
      set_exp(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   // Single compare process: every cycle, DUT outputs against the expectation.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready",   32'(req_ready),   32'(e_rr));
         chk("mem_enable",  32'(mem_enable),  32'(e_en));
         chk("mem_wr",      32'(mem_wr),      32'(e_wr));
         chk("mem_addr",    32'(mem_addr),    32'(e_addr));
         chk("mem_wdata",   mem_wdata,        e_wdata);
         chk("rsp_valid",   32'(rsp_valid),   32'(e_rv));
         chk("rsp_rdata",   rsp_rdata,        e_rdata);
         chk("rsp_err",     32'(rsp_err),     32'(e_err));
         chk("rsp_timeout", 32'(rsp_timeout), 32'(e_tmo));
         if (mem_enable) en_cycles++;
         if (rsp_valid && rsp_ready) begin
            rsp_count++;
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            last_tmo   = rsp_timeout;
         end
      end
   end

   // One word transaction. delay = cycles mem_ready stays low (>= TMO means never).
   // The pipeline keeps req_valid high with junk while busy to prove it is ignored.
   task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                          input int delay, input logic [31:0] rd, input logic merr,
                          input int hold, output int n_mem_o);
      logic        misal, tmo, err;
      logic [31:0] exp_rd;
      int          n_mem;
      misal  = (addr[1:0] != 2'b00);
      tmo    = !misal && (delay >= int'(TMO));
      n_mem  = misal ? 0 : (tmo ? int'(TMO) : delay + 1);
      err    = misal || tmo || merr;
      exp_rd = (!wr && !err) ? rd : 32'h0;
      en_cycles = 0;
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_size = SZ_WORD;
      set_idle();
      @(posedge clk); #1;
      for (int i = 0; i < n_mem; i++) begin
         req_addr  = 16'($urandom); req_wdata = $urandom; req_wr = 1'($urandom);
         mem_ready = (i == delay);
         mem_rdata = (i == delay) ? rd : $urandom;
         mem_err   = (i == delay) ? merr : 1'($urandom);
         set_exp(1'b0, 1'b1, wr, addr, wr ? wdata : 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
         @(posedge clk); #1;
      end
      mem_ready = 1'b0; mem_err = 1'b0;
      for (int j = 0; j <= hold; j++) begin
         req_addr  = 16'($urandom); req_wdata = $urandom; mem_rdata = $urandom;
         rsp_ready = (j == hold);
         set_exp(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, exp_rd, err, tmo);
         @(posedge clk); #1;
      end
      req_valid = 1'b0; rsp_ready = 1'b0;
      set_idle();
      n_mem_o = n_mem;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int saved_rsp;
      rst = 1'b0;
      req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_size = SZ_WORD;
      rsp_ready = 1'b0; mem_rdata = '0; mem_ready = 1'b0; mem_err = 1'b0;
      set_idle();
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // 1: load with three wait cycles
      run_txn(1'b0, 16'h0010, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0, n);
      chk("t1_model_len", 32'(n), 32'd4);
      chk("t1_en_cycles", 32'(en_cycles), 32'd4);
      chk("t1_rdata", last_rdata, 32'hDEADBEEF);

      // 2: store, immediate ready, response back-pressured 5 cycles
      run_txn(1'b1, 16'h0020, 32'h12345678, 0, 32'hFFFFFFFF, 1'b0, 5, n);
      chk("t2_en_cycles", 32'(en_cycles), 32'd1);
      chk("t2_rdata", last_rdata, 32'h0);

      // 3: misaligned word load, no memory access
      run_txn(1'b0, 16'h0022, 32'h0, 0, 32'h0, 1'b0, 0, n);
      chk("t3_en_cycles", 32'(en_cycles), 32'd0);
      chk("t3_err", 32'(last_err), 32'd1);
      chk("t3_tmo", 32'(last_tmo), 32'd0);
      run_txn(1'b1, 16'h0023, 32'hA5A5A5A5, 0, 32'h0, 1'b0, 2, n);

      // 4: memory never answers
      run_txn(1'b0, 16'h0040, 32'h0, 1000, 32'h0, 1'b0, 1, n);
      chk("t4_model_len", 32'(n), 32'd16);
      chk("t4_en_cycles", 32'(en_cycles), 32'd16);
      chk("t4_err", 32'(last_err), 32'd1);
      chk("t4_tmo", 32'(last_tmo), 32'd1);

      // Ready on the last allowed wait cycle is still a success.
      run_txn(1'b0, 16'h0050, 32'h0, 15, 32'h0BADCAFE, 1'b0, 0, n);
      chk("edge_en_cycles", 32'(en_cycles), 32'd16);
      chk("edge_tmo", 32'(last_tmo), 32'd0);
      chk("edge_rdata", last_rdata, 32'h0BADCAFE);

      // Memory error on a load returns err with zero data.
      run_txn(1'b0, 16'h0044, 32'h0, 1, 32'hCAFEF00D, 1'b1, 0, n);
      chk("merr_rdata", last_rdata, 32'h0);
      run_txn(1'b1, 16'h0048, 32'h01020304, 2, 32'h0, 1'b1, 0, n);
      chk("merr_st_err", 32'(last_err), 32'd1);

      // 5: reset in the second ACCESS cycle
      saved_rsp = rsp_count;
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0060; req_size = SZ_WORD;
      set_idle();
      @(posedge clk); #1;
      req_valid = 1'b0; mem_ready = 1'b0;
      set_exp(1'b0, 1'b1, 1'b0, 16'h0060, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      set_idle();
      #1 chk("t5_en_drop", 32'(mem_enable), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("t5_no_rsp", 32'(rsp_count - saved_rsp), 32'd0);
      run_txn(1'b0, 16'h0064, 32'h0, 2, 32'h55AA55AA, 1'b0, 1, n);
      chk("t5_after_en", 32'(en_cycles), 32'd3);
      chk("t5_after_rdata", last_rdata, 32'h55AA55AA);

`ifdef MEM_RMW_EN
      // 6: byte store via read-modify-write
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0031; req_wdata = 32'h000000AB;
      req_size = SZ_BYTE;
      set_idle();
      @(posedge clk); #1;
      req_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h11223344;
      set_exp(1'b0, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      mem_rdata = $urandom;
      set_exp(1'b0, 1'b1, 1'b1, 16'h0030, 32'h1122AB44, 1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      mem_ready = 1'b0; rsp_ready = 1'b1;
      set_exp(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      set_idle();
      chk("t6_err", 32'(last_err), 32'd0);

      // Byte load from 0x0031 returns lane 1 zero-extended.
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0031; req_size = SZ_BYTE;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h11223344;
      set_exp(1'b0, 1'b1, 1'b0, 16'h0030, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      mem_ready = 1'b0; rsp_ready = 1'b1;
      set_exp(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 32'h00000033, 1'b0, 1'b0);
      @(posedge clk); #1;
      rsp_ready = 1'b0; req_size = SZ_WORD;
      set_idle();
      chk("t6_ld_rdata", last_rdata, 32'h00000033);
`endif

      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
Initiator-side controller for the stalling, ready-handshaked, byte-addressed 32-bit data memory used by the processor.
- Accepts one load/store request at a time from the pipeline over a valid/ready interface.
- Drives enable/wr/addr/data to the memory and holds them stable until the memory asserts ready.
- Returns read data plus an error/timeout status over a valid/ready response interface.
- Sits between the load/store stage and the data memory.

Parameters:
TIMEOUT, 16, maximum cycles a memory phase waits for mem_ready before aborting (must be >= 2).
CNT_W, 5, width of the wait counter (must satisfy 2^CNT_W > TIMEOUT).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request (high only in IDLE).
req_wr  in  1  1 = store, 0 = load.
req_addr  in  16  byte address.
req_wdata  in  32  store data.
req_size  in  2  00 = byte, 01 = half, 10 = word; used only with MEM_RMW_EN.
rsp_valid  out  1  response present.
rsp_ready  in  1  response consumed.
rsp_rdata  out  32  load data; 0 for stores and errors.
rsp_err  out  1  misaligned access, memory error, or timeout.
rsp_timeout  out  1  abort caused by timeout (rsp_err is also 1).
mem_enable  out  1  memory access request.
mem_wr  out  1  memory write.
mem_addr  out  16  memory address.
mem_wdata  out  32  memory write data.
mem_rdata  in  32  memory read data, valid combinationally in a cycle where mem_ready is high.
mem_ready  in  1  memory completed the access this cycle.
mem_err  in  1  memory flagged the access as invalid.

Behaviour:
- States: IDLE, ACCESS, RMW_RD, RMW_WR, RESP. RMW_RD and RMW_WR exist only with MEM_RMW_EN.
- Reset (rst low, asynchronous):
  - State goes to IDLE and the wait counter clears.
  - mem_enable, mem_wr, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_err and rsp_timeout are all 0.
  - req_ready is 1 once state is IDLE.
- mem_enable is decoded from the state register: high in ACCESS, RMW_RD and RMW_WR, low otherwise. mem_wr, mem_addr and mem_wdata come from the captured request registers and are 0 outside memory phases.
- IDLE:
  - req_valid & req_ready captures req_* into registers.
  - Misaligned access (word: addr[1:0]!=0; half: addr[0]=1) goes to RESP with rsp_err=1 and issues no memory access.
  - Otherwise go to ACCESS. With MEM_RMW_EN, a sub-word store goes to RMW_RD instead.
- ACCESS:
  - Request signals are held constant every cycle.
  - The wait counter increments on each cycle with mem_ready=0.
  - On mem_ready=1: loads latch mem_rdata into rsp_rdata; rsp_err takes mem_err; go to RESP. The store takes effect at that same clock edge.
  - If the counter reaches TIMEOUT-1 with mem_ready still low: rsp_err=1, rsp_timeout=1, go to RESP. mem_enable drops the following cycle.
- The wait counter clears on entry to every memory phase.
- RESP: rsp_valid=1 with payload held stable until rsp_ready=1; then go to IDLE. No new request is accepted in the handshake cycle.
- Latency: accept at edge N with mem_ready immediately high gives rsp_valid at N+2. The misaligned path gives rsp_valid at N+1.
- Reset mid-operation: the outstanding request is discarded, no response is produced, and mem_enable falls immediately.

Optional Feature:
MEM_RMW_EN
- Defined: req_size is honoured.
- Sub-word load:
  - Reads the word at addr&~3.
  - rsp_rdata is the addressed byte or half, zero-extended.
- Sub-word store:
  - RMW_RD reads the word at addr&~3.
  - RMW_WR writes back that word with the addressed lanes replaced by req_wdata's low byte or half.
  - TIMEOUT applies to each phase separately.
  - mem_err or a timeout in RMW_RD aborts the store with no write.
- Undefined: req_size is ignored, every access is a word access, and the RMW states are absent.

Decomposition:
- Package mem_req_pkg holds:
  - the state enum;
  - the size constants SZ_BYTE, SZ_HALF, SZ_WORD;
  - the default TIMEOUT.
- One combinational sub-module, mem_rmw_merge, performs lane extract and merge. It is instantiated only under MEM_RMW_EN.

Test Plan:
1. Load 0x0010, mem_ready low 3 cycles then high with mem_rdata=0xDEADBEEF -> mem_enable high 4 cycles with addr stable at 0x0010; rsp_valid with rdata=0xDEADBEEF, err=0.
2. Store 0x12345678 to 0x0020, mem_ready high at once, rsp_ready low 5 cycles -> exactly one mem_enable&mem_wr cycle; rsp held 5 cycles with rdata=0; req_ready=0 until the handshake.
3. Word load at 0x0022 -> no mem_enable; rsp_valid next cycle with rsp_err=1, rsp_timeout=0.
4. mem_ready stuck low, TIMEOUT=16 -> mem_enable high exactly 16 cycles; then rsp_err=1, rsp_timeout=1.
5. rst pulled low in the second ACCESS cycle -> mem_enable 0 immediately; no rsp_valid after release; the next request is serviced normally.
6. MEM_RMW_EN: memory word at 0x0030 = 0x11223344, byte store 0xAB to 0x0031 -> read at 0x0030, then write 0x1122AB44 to 0x0030, rsp_err=0.
